// File: rtl/gpu_pkg.sv
// gpu_pkg: shared sizing defaults and dispatch FSM state encoding.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

package gpu_pkg;

  localparam int NCORES = 16;
  localparam int MSG_W  = 32;
  localparam int DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/msg_fifo.sv
// msg_fifo: per-core message FIFO, power-of-two depth, show-ahead head output.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module msg_fifo #(
  parameter int MSG_W = gpu_pkg::MSG_W,
  parameter int DEPTH = gpu_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [MSG_W-1:0] din,
  output logic [MSG_W-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [MSG_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/dispatch_fanout.sv
// dispatch_fanout: broadcasts a counted group of messages into per-core FIFOs
// and releases the core group once all cores have drained and reported done.
`default_nettype none
`timescale 1ns/1ps

module dispatch_fanout #(
  parameter int NCORES = gpu_pkg::NCORES,
  parameter int MSG_W  = gpu_pkg::MSG_W,
  parameter int DEPTH  = gpu_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    grp_load,
  input  logic [NCORES-1:0]       grp_mask,
  input  logic [5:0]              grp_count,
  input  logic                    msg_valid,
  input  logic [MSG_W-1:0]        msg_data,
  output logic                    msg_ready,
  input  logic [NCORES-1:0]       core_pop,
  output logic [NCORES*MSG_W-1:0] core_msg,
  output logic [NCORES-1:0]       core_empty,
  input  logic [NCORES-1:0]       core_done,
  output logic [NCORES-1:0]       release_mask,
  output logic                    busy,
  output logic                    load_err
);

  import gpu_pkg::*;

  state_t            state;
  logic [NCORES-1:0] mask_q;
  logic [NCORES-1:0] done_q;
  logic [5:0]        remain;
  logic [NCORES-1:0] fifo_full;
  logic              xfer;
  logic              all_empty;
  logic              all_done;

  // Full is taken from registered occupancy, so a pop this cycle cannot unblock.
  assign msg_ready = (state == RUN) && !(|(fifo_full & mask_q));
  assign xfer      = msg_valid & msg_ready;
  assign busy      = (state != IDLE);
  assign all_empty = !(|(~core_empty & mask_q));
  assign all_done  = ((done_q & mask_q) == mask_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_q       <= '0;
      done_q       <= '0;
      remain       <= '0;
      release_mask <= '0;
      load_err     <= 1'b0;
    end else begin
      release_mask <= '0;
      load_err     <= 1'b0;
      done_q       <= done_q | (core_done & mask_q);
      case (state)
        IDLE: begin
          if (grp_load) begin
            mask_q <= grp_mask;
            remain <= grp_count;
            done_q <= '0;
            // Nothing to send: skip straight to the completion wait.
            if (grp_count == 6'd0 || grp_mask == '0) state <= DRAIN;
            else                                     state <= RUN;
          end
        end
        RUN: begin
          if (grp_load) load_err <= 1'b1;
          if (xfer) begin
            remain <= remain - 6'd1;
            if (remain == 6'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (grp_load) load_err <= 1'b1;
          if (all_empty && all_done) begin
            state        <= IDLE;
            release_mask <= mask_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NCORES; i++) begin : g_core
    msg_fifo #(
      .MSG_W (MSG_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (xfer & mask_q[i]),
      .pop   (core_pop[i]),
      .din   (msg_data),
      .dout  (core_msg[i*MSG_W +: MSG_W]),
      .empty (core_empty[i]),
      .full  (fifo_full[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_dispatch_fanout.sv
// tb_dispatch_fanout: scoreboard-driven scenario bench for dispatch_fanout.
`default_nettype none
`timescale 1ns/1ps

module tb_dispatch_fanout;

  localparam int NC = 16;
  localparam int MW = 32;
  localparam int DP = 4;

  logic              clk;
  logic              rst_n;
  logic              grp_load;
  logic [NC-1:0]     grp_mask;
  logic [5:0]        grp_count;
  logic              msg_valid;
  logic [MW-1:0]     msg_data;
  logic              msg_ready;
  logic [NC-1:0]     core_pop;
  logic [NC*MW-1:0]  core_msg;
  logic [NC-1:0]     core_empty;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     release_mask;
  logic              busy;
  logic              load_err;

  int n_vec;
  int n_err;
  logic [MW-1:0] sb [NC][$];
  logic [NC-1:0] cur_mask;

  dispatch_fanout #(
    .NCORES (NC),
    .MSG_W  (MW),
    .DEPTH  (DP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .grp_load     (grp_load),
    .grp_mask     (grp_mask),
    .grp_count    (grp_count),
    .msg_valid    (msg_valid),
    .msg_data     (msg_data),
    .msg_ready    (msg_ready),
    .core_pop     (core_pop),
    .core_msg     (core_msg),
    .core_empty   (core_empty),
    .core_done    (core_done),
    .release_mask (release_mask),
    .busy         (busy),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_group(input logic [NC-1:0] m, input logic [5:0] c);
    grp_load  = 1'b1;
    grp_mask  = m;
    grp_count = c;
    tick();
    grp_load  = 1'b0;
    grp_mask  = '0;
    grp_count = '0;
    cur_mask  = m;
  endtask

  task automatic send_word(input logic [MW-1:0] d);
    int w;
    w = 0;
    msg_valid = 1'b1;
    msg_data  = d;
    while (msg_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    n_vec++;
    if (msg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_timeout msg_ready=%b required=1", msg_ready);
    end else begin
      for (int c = 0; c < NC; c++)
        if (cur_mask[c]) sb[c].push_back(d);
      tick();
    end
    msg_valid = 1'b0;
  endtask

  task automatic pop_core(input int c);
    logic [MW-1:0] exp;
    n_vec++;
    if (sb[c].size() == 0) begin
      n_err++;
      $display("FAIL pop_core%0d scoreboard empty, core_empty=%b", c, core_empty[c]);
    end else begin
      exp = sb[c].pop_front();
      if (core_empty[c] !== 1'b0 || core_msg[c*MW +: MW] !== exp) begin
        n_err++;
        $display("FAIL pop_core%0d head=%h empty=%b required head=%h empty=0",
                 c, core_msg[c*MW +: MW], core_empty[c], exp);
      end
    end
    core_pop[c] = 1'b1;
    tick();
    core_pop[c] = 1'b0;
  endtask

  task automatic finish_group(input logic [NC-1:0] done_bits, input logic [NC-1:0] exp_rel);
    int w;
    int early;
    w = 0;
    early = 0;
    core_done = done_bits;
    tick();
    core_done = '0;
    while (busy === 1'b1 && w < 20) begin
      if (release_mask !== '0) early++;
      tick();
      w++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL group_end_timeout busy=%b required=0", busy);
    end
    n_vec++;
    if (release_mask !== exp_rel || early != 0) begin
      n_err++;
      $display("FAIL release_value release_mask=%h early=%0d required=%h early=0",
               release_mask, early, exp_rel);
    end
    tick();
    n_vec++;
    if (release_mask !== '0) begin
      n_err++;
      $display("FAIL release_width release_mask=%h required=0", release_mask);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (msg_ready !== 1'b0 || busy !== 1'b0 || load_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl ready=%b busy=%b load_err=%b required 0/0/0", msg_ready, busy, load_err);
    end
    n_vec++;
    if (release_mask !== '0 || core_empty !== '1 || core_msg !== '0) begin
      n_err++;
      $display("FAIL reset_data release=%h empty=%h msg_nonzero=%b required 0/ffff/0",
               release_mask, core_empty, |core_msg);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    load_group(16'h0003, 6'd2);
    n_vec++;
    if (busy !== 1'b1 || msg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_run busy=%b ready=%b required 1/1", busy, msg_ready);
    end
    send_word(32'hDEADBEEF);
    n_vec++;
    if (core_empty[1:0] !== 2'b00 || core_msg[0 +: MW] !== 32'hDEADBEEF || core_msg[MW +: MW] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL basic_latency empty=%b head0=%h head1=%h required 00/deadbeef/deadbeef",
               core_empty[1:0], core_msg[0 +: MW], core_msg[MW +: MW]);
    end
    send_word(32'h12345678);
    n_vec++;
    if (msg_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_drain ready=%b busy=%b required 0/1", msg_ready, busy);
    end
    pop_core(0);
    pop_core(0);
    pop_core(1);
    pop_core(1);
    finish_group(16'h0003, 16'h0003);
  endtask

  task automatic test_backpressure;
    load_group(16'h0001, 6'd6);
    for (int k = 0; k < 4; k++) send_word(32'hA000_0000 + k);
    msg_valid = 1'b1;
    msg_data  = 32'hA000_0004;
    n_vec++;
    if (msg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full msg_ready=%b required=0", msg_ready);
    end
    pop_core(0);
    n_vec++;
    if (msg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_unblock msg_ready=%b required=1", msg_ready);
    end
    send_word(32'hA000_0004);
    pop_core(0);
    send_word(32'hA000_0005);
    n_vec++;
    if (msg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain msg_ready=%b required=0", msg_ready);
    end
    for (int k = 0; k < 4; k++) pop_core(0);
    finish_group(16'h0001, 16'h0001);
  endtask

  task automatic test_push_pop_same_cycle;
    load_group(16'h0001, 6'd4);
    send_word(32'h0000_00A1);
    send_word(32'h0000_00B2);
    msg_valid = 1'b1;
    msg_data  = 32'h0000_00C3;
    n_vec++;
    if (msg_ready !== 1'b1 || core_msg[0 +: MW] !== sb[0][0]) begin
      n_err++;
      $display("FAIL pp_pre ready=%b head=%h required 1/%h", msg_ready, core_msg[0 +: MW], sb[0][0]);
    end
    sb[0].push_back(32'h0000_00C3);
    void'(sb[0].pop_front());
    core_pop[0] = 1'b1;
    tick();
    core_pop[0] = 1'b0;
    msg_valid   = 1'b0;
    n_vec++;
    if (core_empty[0] !== 1'b0 || core_msg[0 +: MW] !== 32'h0000_00B2) begin
      n_err++;
      $display("FAIL pp_head head=%h empty=%b required 000000b2/0", core_msg[0 +: MW], core_empty[0]);
    end
    send_word(32'h0000_00D4);
    pop_core(0);
    pop_core(0);
    pop_core(0);
    n_vec++;
    if (core_empty[0] !== 1'b1) begin
      n_err++;
      $display("FAIL pp_occupancy core_empty=%b required=1", core_empty[0]);
    end
    finish_group(16'h0001, 16'h0001);
  endtask

  task automatic test_load_in_run;
    load_group(16'h0002, 6'd3);
    send_word(32'h1111_0001);
    grp_load  = 1'b1;
    grp_mask  = 16'h00F0;
    grp_count = 6'd1;
    tick();
    grp_load  = 1'b0;
    grp_mask  = '0;
    grp_count = '0;
    n_vec++;
    if (load_err !== 1'b1) begin
      n_err++;
      $display("FAIL load_err_pulse load_err=%b required=1", load_err);
    end
    tick();
    n_vec++;
    if (load_err !== 1'b0) begin
      n_err++;
      $display("FAIL load_err_width load_err=%b required=0", load_err);
    end
    send_word(32'h1111_0002);
    n_vec++;
    if (msg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_count_kept msg_ready=%b required=1", msg_ready);
    end
    send_word(32'h1111_0003);
    n_vec++;
    if (msg_ready !== 1'b0 || busy !== 1'b1 || core_empty[4] !== 1'b1 || core_empty[1] !== 1'b0) begin
      n_err++;
      $display("FAIL load_mask_kept ready=%b busy=%b empty4=%b empty1=%b required 0/1/1/0",
               msg_ready, busy, core_empty[4], core_empty[1]);
    end
    for (int k = 0; k < 3; k++) pop_core(1);
    finish_group(16'h0012, 16'h0002);
  endtask

  task automatic test_zero_count;
    load_group(16'h8000, 6'd0);
    n_vec++;
    if (busy !== 1'b1 || msg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zc_drain busy=%b ready=%b required 1/0", busy, msg_ready);
    end
    tick();
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b1 || release_mask !== '0) begin
      n_err++;
      $display("FAIL zc_wait_done busy=%b release=%h required 1/0000", busy, release_mask);
    end
    finish_group(16'h8000, 16'h8000);
  endtask

  task automatic test_zero_mask;
    load_group(16'h0000, 6'd3);
    n_vec++;
    if (msg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zm_ready msg_ready=%b required=0", msg_ready);
    end
    finish_group(16'h0000, 16'h0000);
  endtask

  task automatic test_reset_mid_run;
    load_group(16'h0003, 6'd5);
    send_word(32'hC0DE_0001);
    send_word(32'hC0DE_0002);
    send_word(32'hC0DE_0003);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (core_empty !== '1 || busy !== 1'b0 || release_mask !== '0 || msg_ready !== 1'b0 || core_msg !== '0) begin
      n_err++;
      $display("FAIL rst_mid_async empty=%h busy=%b release=%h ready=%b msg_nonzero=%b required ffff/0/0/0/0",
               core_empty, busy, release_mask, msg_ready, |core_msg);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < NC; c++) sb[c].delete();
    tick();
    tick();
    n_vec++;
    if (core_empty !== '1 || busy !== 1'b0 || release_mask !== '0) begin
      n_err++;
      $display("FAIL rst_mid_after empty=%h busy=%b release=%h required ffff/0/0",
               core_empty, busy, release_mask);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cur_mask  = '0;
    rst_n     = 1'b0;
    grp_load  = 1'b0;
    grp_mask  = '0;
    grp_count = '0;
    msg_valid = 1'b0;
    msg_data  = '0;
    core_pop  = '0;
    core_done = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_push_pop_same_cycle();
    test_load_in_run();
    test_zero_count();
    test_zero_mask();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
